// File: rtl/hysteresis_bram_writer.sv
// Drains the hysteresis FIFO into the frame BRAM in raster order, then hands the frame to Hough.
// Optional macro BORDER_ZERO_EN: border pixels are consumed but written as 8'h00.
module hysteresis_bram_writer #(
  parameter int WIDTH       = 720,
  parameter int HEIGHT      = 540,
  parameter int IMAGE_SIZE  = WIDTH * HEIGHT,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_empty,
  output logic                          in_rd_en,
  input  logic [7:0]                    in_dout,
  output logic                          bram_wr_en,
  output logic [$clog2(IMAGE_SIZE)-1:0] bram_wr_addr,
  output logic [7:0]                    bram_wr_data,
  output logic                          hough_start,
  input  logic                          hough_done,
  output logic                          busy,
  output logic [FRAME_CNT_W-1:0]        frame_count
);

  localparam int AW = $clog2(IMAGE_SIZE);
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {FILL, START, WAIT_HOUGH} state_t;

  state_t                 state_q, state_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic                   wr_en_q;
  logic [AW-1:0]          wr_addr_q;
  logic [7:0]             wr_data_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [AW-1:0]          lin_addr;
  logic [7:0]             pix_d;
  logic                   rd;
  logic                   last_col, last_row;

  assign last_col = (x_q == XW'(WIDTH - 1));
  assign last_row = (y_q == YW'(HEIGHT - 1));

  always_ff @(posedge clock) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:       if (rd && last_col && last_row) state_d = START;
      START:      state_d = WAIT_HOUGH;
      WAIT_HOUGH: if (hough_done) state_d = FILL;
      default:    state_d = FILL;
    endcase
  end

  always_comb begin
    rd          = (state_q == FILL) && !in_empty;
    in_rd_en    = rd;
    hough_start = (state_q == START);
    busy        = (state_q != FILL);
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (rd) begin
      if (last_col) begin
        x_d = '0;
        y_d = last_row ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_q == WAIT_HOUGH && hough_done) frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
  end

  assign lin_addr = AW'(y_q) * AW'(WIDTH) + AW'(x_q);

`ifdef BORDER_ZERO_EN
  always_comb begin
    pix_d = in_dout;
    if (x_q == '0 || last_col || y_q == '0 || last_row) pix_d = '0;
  end
`else
  assign pix_d = in_dout;
`endif

  // Write stage trails the read by one cycle; address/data hold when no read occurs.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      wr_en_q     <= rd;
      frame_cnt_q <= frame_cnt_d;
      if (rd) begin
        wr_addr_q <= lin_addr;
        wr_data_q <= pix_d;
      end
    end
  end

  assign bram_wr_en   = wr_en_q;
  assign bram_wr_addr = wr_addr_q;
  assign bram_wr_data = wr_data_q;
  assign frame_count  = frame_cnt_q;

endmodule
